// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads one 16-bit word per step over a
// ready handshake, and holds it for the decoder until execute retires it.
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        halt,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ready,
  output logic [15:0] instruction,
  output logic        instr_valid,
  output logic [15:0] pc,
  input  logic        exec_done,
  input  logic        pc_wr,
  input  logic [15:0] pc_next
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_EXEC  = 2'd2
  } state_t;

  state_t      state_r;
  state_t      state_s;
  logic [15:0] pc_s;
  logic [15:0] mem_addr_s;
  logic [15:0] instruction_s;
  logic        mem_rd_s;
  logic        instr_valid_s;

  // Next-state and next-output logic; everything holds unless a transition fires.
  always_comb begin
    state_s       = state_r;
    pc_s          = pc;
    mem_addr_s    = mem_addr;
    instruction_s = instruction;
    mem_rd_s      = mem_rd;
    instr_valid_s = instr_valid;
    case (state_r)
      S_FETCH: begin
        if (!halt) begin
          mem_addr_s = pc;
          mem_rd_s   = 1'b1;
          state_s    = S_WAIT;
        end else begin
          mem_rd_s   = 1'b0;
        end
      end
      S_WAIT: begin
        // halt is deliberately not consulted: an issued request always completes.
        if (mem_ready) begin
          instruction_s = mem_rdata;
          mem_rd_s      = 1'b0;
          instr_valid_s = 1'b1;
          state_s       = S_EXEC;
        end else begin
          mem_rd_s      = 1'b1;
        end
      end
      S_EXEC: begin
        if (exec_done) begin
          instr_valid_s = 1'b0;
          state_s       = S_FETCH;
          if (pc_wr) begin
            pc_s = pc_next;
          end else begin
            pc_s = pc + 16'd1;
          end
        end else begin
          instr_valid_s = 1'b1;
        end
      end
      default: begin
        state_s       = S_FETCH;
        mem_rd_s      = 1'b0;
        instr_valid_s = 1'b0;
      end
    endcase
  end

  // State and output registers; reset takes priority over any same-edge handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= S_FETCH;
      pc          <= RESET_PC;
      mem_addr    <= 16'h0000;
      mem_rd      <= 1'b0;
      instruction <= 16'h0000;
      instr_valid <= 1'b0;
    end else begin
      state_r     <= state_s;
      pc          <= pc_s;
      mem_addr    <= mem_addr_s;
      mem_rd      <= mem_rd_s;
      instruction <= instruction_s;
      instr_valid <= instr_valid_s;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized traffic,
// all compared every cycle against a behavioural model of the fetch protocol.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst, halt, mem_ready, exec_done, pc_wr;
  logic [15:0] mem_rdata, pc_next;
  logic [15:0] mem_addr, instruction, pc;
  logic        mem_rd, instr_valid;
  logic [15:0] w_mem_addr, w_instruction, w_pc;
  logic        w_mem_rd, w_instr_valid;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  // Model of the observable behaviour
  logic [15:0] m_pc, m_addr, m_instr;
  logic        m_rd, m_valid;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(16'h0000)) dut (
    .clk(clk), .rst(rst), .halt(halt),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .instruction(instruction), .instr_valid(instr_valid), .pc(pc),
    .exec_done(exec_done), .pc_wr(pc_wr), .pc_next(pc_next)
  );

  fetch_unit #(.RESET_PC(16'hFFFF)) u_wrap (
    .clk(clk), .rst(rst), .halt(halt),
    .mem_addr(w_mem_addr), .mem_rd(w_mem_rd), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .instruction(w_instruction), .instr_valid(w_instr_valid), .pc(w_pc),
    .exec_done(exec_done), .pc_wr(pc_wr), .pc_next(pc_next)
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: waiting on memory, holding an instruction, or idle-and-ready-to-fetch.
  always @(posedge clk) begin
    if (rst) begin
      m_pc <= 16'h0000; m_addr <= 16'h0000; m_instr <= 16'h0000;
      m_rd <= 1'b0; m_valid <= 1'b0;
    end else if (m_rd) begin
      if (mem_ready) begin
        m_instr <= mem_rdata; m_rd <= 1'b0; m_valid <= 1'b1;
      end
    end else if (m_valid) begin
      if (exec_done) begin
        m_valid <= 1'b0;
        m_pc    <= pc_wr ? pc_next : m_pc + 16'd1;
      end
    end else if (!halt) begin
      m_addr <= m_pc; m_rd <= 1'b1;
    end
  end

  // Compare process, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      check("model_pc", pc, m_pc);
      check("model_mem_rd", {15'd0, mem_rd}, {15'd0, m_rd});
      check("model_instr_valid", {15'd0, instr_valid}, {15'd0, m_valid});
      check("model_instruction", instruction, m_instr);
      if (m_rd) check("model_mem_addr", mem_addr, m_addr);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; halt = 1'b0; mem_ready = 1'b0; exec_done = 1'b0;
    pc_wr = 1'b0; mem_rdata = 16'h0000; pc_next = 16'h0000;
    step(); step();
    chk_en = 1'b1;
    check("rst_pc", pc, 16'h0000);
    check("rst_mem_rd", {15'd0, mem_rd}, 16'd0);
    check("rst_valid", {15'd0, instr_valid}, 16'd0);
    check("rst_instruction", instruction, 16'h0000);
    check("rst_mem_addr", mem_addr, 16'h0000);

    // Reset release and first fetch with memory always ready
    rst = 1'b0; mem_ready = 1'b1; mem_rdata = 16'h2125;
    step();
    check("first_mem_rd", {15'd0, mem_rd}, 16'd1);
    check("first_mem_addr", mem_addr, 16'h0000);
    step();
    check("first_instruction", instruction, 16'h2125);
    check("first_valid", {15'd0, instr_valid}, 16'd1);
    check("first_rd_drop", {15'd0, mem_rd}, 16'd0);
    check("first_pc", pc, 16'h0000);
    mem_ready = 1'b0; exec_done = 1'b1;
    step();
    exec_done = 1'b0;
    check("first_retire_pc", pc, 16'h0001);

    // Sequential stream with 3 wait cycles per access
    rst = 1'b1; step(); rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      check("seq_issue_addr", mem_addr, 16'(k));
      repeat (3) begin
        step();
        check("seq_wait_rd", {15'd0, mem_rd}, 16'd1);
        check("seq_wait_addr", mem_addr, 16'(k));
      end
      mem_ready = 1'b1; mem_rdata = 16'hA000 + 16'(k);
      step();
      mem_ready = 1'b0;
      check("seq_instruction", instruction, 16'hA000 + 16'(k));
      step(); step();
      check("seq_hold_valid", {15'd0, instr_valid}, 16'd1);
      exec_done = 1'b1;
      step();
      exec_done = 1'b0;
      check("seq_retire_pc", pc, 16'(k + 1));
    end

    // Branch redirect, and pc_wr without exec_done ignored
    step();
    mem_ready = 1'b1; step(); mem_ready = 1'b0;
    pc_wr = 1'b1; pc_next = 16'h1234;
    step(); step();
    check("pc_wr_alone_pc", pc, 16'h0004);
    check("pc_wr_alone_valid", {15'd0, instr_valid}, 16'd1);
    exec_done = 1'b1; pc_next = 16'h0040;
    step();
    exec_done = 1'b0; pc_wr = 1'b0;
    check("branch_pc", pc, 16'h0040);
    step();
    check("branch_mem_addr", mem_addr, 16'h0040);

    // Halt before first fetch, then during WAIT and EXEC
    rst = 1'b1; halt = 1'b1; step(); rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      check("halt_no_rd", {15'd0, mem_rd}, 16'd0);
    end
    halt = 1'b0;
    step();
    check("halt_release_rd", {15'd0, mem_rd}, 16'd1);
    halt = 1'b1;
    step(); step();
    check("halt_in_wait_rd", {15'd0, mem_rd}, 16'd1);
    mem_ready = 1'b1; mem_rdata = 16'h5EED; step(); mem_ready = 1'b0;
    check("halt_in_wait_valid", {15'd0, instr_valid}, 16'd1);
    exec_done = 1'b1; step(); exec_done = 1'b0;
    check("halt_retire_pc", pc, 16'h0001);
    step();
    check("halt_refetch_blocked", {15'd0, mem_rd}, 16'd0);
    halt = 1'b0;

    // Reset mid-WAIT colliding with mem_ready
    step();
    rst = 1'b1; mem_ready = 1'b1; step(); rst = 1'b0; mem_ready = 1'b0;
    check("rst_wait_rd", {15'd0, mem_rd}, 16'd0);
    check("rst_wait_valid", {15'd0, instr_valid}, 16'd0);
    check("rst_wait_pc", pc, 16'h0000);

    // Reset colliding with exec_done + pc_wr
    step();
    mem_ready = 1'b1; step(); mem_ready = 1'b0;
    exec_done = 1'b1; pc_wr = 1'b1; pc_next = 16'h0040; rst = 1'b1;
    step();
    exec_done = 1'b0; pc_wr = 1'b0; rst = 1'b0;
    check("rst_exec_pc", pc, 16'h0000);
    check("rst_exec_valid", {15'd0, instr_valid}, 16'd0);

    // Wrap-around on the RESET_PC=16'hFFFF instance
    check("wrap_reset_pc", w_pc, 16'hFFFF);
    step();
    check("wrap_first_addr", w_mem_addr, 16'hFFFF);
    mem_ready = 1'b1; step(); mem_ready = 1'b0;
    exec_done = 1'b1; step(); exec_done = 1'b0;
    check("wrap_pc", w_pc, 16'h0000);
    step();
    check("wrap_next_addr", w_mem_addr, 16'h0000);
    check("wrap_next_rd", {15'd0, w_mem_rd}, 16'd1);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 99) == 0);
      halt      = ($urandom_range(0, 3) == 0);
      mem_ready = ($urandom_range(0, 2) == 0);
      exec_done = ($urandom_range(0, 2) == 0);
      pc_wr     = $urandom_range(0, 1) == 1;
      pc_next   = 16'($urandom);
      mem_rdata = 16'($urandom);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
